// File: rtl/md4_block.sv
// rtl/md4_block.sv - iterative MD4 compression, one step per clock
// Latches IV and block on a rising irdy, runs 48 steps, then adds the saved IV back in.
module md4_block (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         irdy,
  input  logic [31:0]  in_a,
  input  logic [31:0]  in_b,
  input  logic [31:0]  in_c,
  input  logic [31:0]  in_d,
  input  logic [511:0] data,
  output logic         ordy,
  output logic [31:0]  out_a,
  output logic [31:0]  out_b,
  output logic [31:0]  out_c,
  output logic [31:0]  out_d
);

  typedef enum logic [1:0] {IDLE, BUSY, FINAL, DONE} state_t;

  state_t      state;
  logic        irdy_q;
  logic [5:0]  step;
  logic [31:0] a, b, c, d;
  logic [31:0] sa, sb, sc, sd;
  logic [31:0] x [16];

  logic        start;
  logic [3:0]  idx;
  logic [3:0]  ki;
  logic [4:0]  sh;
  logic [31:0] f, kc, t, a_new;
  logic [63:0] dbl;

  assign start = irdy & ~irdy_q & ((state == IDLE) | (state == DONE));
  assign idx   = step[3:0];

  // Round function, constant, message index and rotation for the current step.
  always_comb begin
    f  = '0;
    kc = '0;
    ki = idx;
    sh = 5'd3;
    case (step[5:4])
      2'd0: begin
        f  = (b & c) | (~b & d);
        kc = 32'h0000_0000;
        ki = idx;
        case (idx[1:0])
          2'd0: sh = 5'd3;
          2'd1: sh = 5'd7;
          2'd2: sh = 5'd11;
          default: sh = 5'd19;
        endcase
      end
      2'd1: begin
        f  = (b & c) | (b & d) | (c & d);
        kc = 32'h5A82_7999;
        ki = {idx[1:0], idx[3:2]};
        case (idx[1:0])
          2'd0: sh = 5'd3;
          2'd1: sh = 5'd5;
          2'd2: sh = 5'd9;
          default: sh = 5'd13;
        endcase
      end
      default: begin
        f  = b ^ c ^ d;
        kc = 32'h6ED9_EBA1;
        ki = {idx[0], idx[1], idx[2], idx[3]};
        case (idx[1:0])
          2'd0: sh = 5'd3;
          2'd1: sh = 5'd9;
          2'd2: sh = 5'd11;
          default: sh = 5'd15;
        endcase
      end
    endcase
  end

  assign t     = a + f + x[ki] + kc;
  assign dbl   = {t, t} << sh;
  assign a_new = dbl[63:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      irdy_q <= 1'b0;
      step   <= '0;
      ordy   <= 1'b0;
      out_a  <= '0;
      out_b  <= '0;
      out_c  <= '0;
      out_d  <= '0;
      a      <= '0;
      b      <= '0;
      c      <= '0;
      d      <= '0;
      sa     <= '0;
      sb     <= '0;
      sc     <= '0;
      sd     <= '0;
      for (int i = 0; i < 16; i++) x[i] <= '0;
    end else begin
      irdy_q <= irdy;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a     <= in_a;
            b     <= in_b;
            c     <= in_c;
            d     <= in_d;
            sa    <= in_a;
            sb    <= in_b;
            sc    <= in_c;
            sd    <= in_d;
            for (int i = 0; i < 16; i++) x[i] <= data[32*i +: 32];
            ordy  <= 1'b0;
            step  <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          a <= d;
          b <= a_new;
          c <= b;
          d <= c;
          if (step == 6'd47) begin
            state <= FINAL;
          end else begin
            step <= step + 6'd1;
          end
        end
        FINAL: begin
          out_a <= sa + a;
          out_b <= sb + b;
          out_c <= sc + c;
          out_d <= sd + d;
          ordy  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md4_block.sv
// tb/tb_md4_block.sv - directed MD4 vectors: known digests, latency, retrigger, reset, isolation
module tb_md4_block;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         irdy;
  logic [31:0]  in_a, in_b, in_c, in_d;
  logic [511:0] data;
  logic         ordy;
  logic [31:0]  out_a, out_b, out_c, out_d;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  logic ordy1;

  md4_block dut (
    .clk   (clk),
    .rst_n (rst_n),
    .irdy  (irdy),
    .in_a  (in_a),
    .in_b  (in_b),
    .in_c  (in_c),
    .in_d  (in_d),
    .data  (data),
    .ordy  (ordy),
    .out_a (out_a),
    .out_b (out_b),
    .out_c (out_c),
    .out_d (out_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_iv();
    in_a = 32'h67452301;
    in_b = 32'hEFCDAB89;
    in_c = 32'h98BADCFE;
    in_d = 32'h10325476;
  endtask

  task automatic set_empty();
    data = '0;
    data[31:0] = 32'h00000080;
  endtask

  task automatic set_abc();
    data = '0;
    data[31:0] = 32'h80636261;
    data[14*32 +: 32] = 32'h00000018;
  endtask

  // mode 0: plain, 1: scramble inputs after start, 2: second irdy edge mid-run
  task automatic go(input int hold, input int mode, input int stop_at,
                    output int l, output logic o1);
    @(negedge clk);
    irdy = 1'b1;
    l = 0;
    o1 = 1'bx;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      l++;
      if (l == 1) o1 = ordy;
      if (l >= hold && !(mode == 2 && l >= 20 && l < 24)) irdy = 1'b0;
      if (mode == 1) begin
        in_a = $urandom; in_b = $urandom; in_c = $urandom; in_d = $urandom;
        data = {16{$urandom}};
      end
      if (mode == 2 && l == 20) begin
        irdy = 1'b1;
        in_a = 32'h11111111; in_b = 32'h22222222; in_c = 32'h33333333; in_d = 32'h44444444;
        data = {16{32'hDEADBEEF}};
      end
      if (stop_at > 0 && l == stop_at) break;
      if (ordy) break;
    end
    irdy = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_a"}, out_a, 32'hE0CFD631);
    check({tag, "_b"}, out_b, 32'h31E96AD1);
    check({tag, "_c"}, out_c, 32'hD7593CB7);
    check({tag, "_d"}, out_d, 32'hC089C0E0);
  endtask

  task automatic check_abc(input string tag);
    check({tag, "_a"}, out_a, 32'h7A0148A4);
    check({tag, "_b"}, out_b, 32'h52D821AF);
    check({tag, "_c"}, out_c, 32'hE80AC15F);
    check({tag, "_d"}, out_d, 32'h9D72A67A);
  endtask

  initial begin
    rst_n = 1'b0;
    irdy  = 1'b0;
    set_iv();
    set_empty();
    #23;
    check("rst_ordy", {31'd0, ordy}, 32'd0);
    check("rst_out_a", out_a, 32'd0);
    check("rst_out_d", out_d, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Empty message, irdy held two cycles
    set_iv();
    set_empty();
    go(2, 0, 0, lat, ordy1);
    check("empty_latency", lat, 32'd50);
    check_empty("empty");

    // abc, irdy held ten cycles: single run, then outputs hold while idle
    set_iv();
    set_abc();
    go(10, 0, 0, lat, ordy1);
    check("abc_latency", lat, 32'd50);
    check("abc_ordy_drop", {31'd0, ordy1}, 32'd0);
    check_abc("abc");
    repeat (20) @(posedge clk);
    #1;
    check("hold_ordy", {31'd0, ordy}, 32'd1);
    check_abc("hold");

    // Retrigger while busy is ignored
    set_iv();
    set_empty();
    go(2, 2, 0, lat, ordy1);
    check("retrig_latency", lat, 32'd50);
    check_empty("retrig");

    // Inputs scrambled every cycle after the start edge
    set_iv();
    set_abc();
    go(2, 1, 0, lat, ordy1);
    check("iso_latency", lat, 32'd50);
    check_abc("iso");

    // Reset mid-run
    set_iv();
    set_empty();
    go(2, 0, 31, lat, ordy1);
    check("pre_rst_ordy", {31'd0, ordy}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_ordy", {31'd0, ordy}, 32'd0);
    check("midrst_out_a", out_a, 32'd0);
    check("midrst_out_c", out_c, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("post_rst_idle", {31'd0, ordy}, 32'd0);

    set_iv();
    set_abc();
    go(2, 0, 0, lat, ordy1);
    check("post_rst_latency", lat, 32'd50);
    check_abc("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/md4_block.md
Name: md4_block

Overview:
- Iterative MD4 compression engine: one 512-bit message block plus a 128-bit chaining state in, updated 128-bit state out.
- Used by the NT-hash cracker controller to hash each candidate password block.
- The controller pulses irdy, waits for ordy, then byte-swaps out_a..out_d into a digest.
- One MD4 step is computed per clock.

Parameters:
- none

Ports:
- clk    input  1    rising-edge clock
- rst_n  input  1    asynchronous active-low reset
- irdy   input  1    start request; rising edge starts a compression
- in_a   input  32   chaining word A (numeric MD4 word)
- in_b   input  32   chaining word B
- in_c   input  32   chaining word C
- in_d   input  32   chaining word D
- data   input  512  message block; X[i] = data[32*i+31 : 32*i], i = 0..15, each a numeric little-endian MD4 word
- ordy   output 1    result valid (level)
- out_a  output 32   resulting word A
- out_b  output 32   resulting word B
- out_c  output 32   resulting word C
- out_d  output 32   resulting word D

Behaviour:
- Clocking and reset:
  - One clock domain (clk); reset is asynchronous and active-low (rst_n).
  - Reset: ordy=0, out_a..out_d=0, FSM=IDLE, step counter=0, irdy edge register=0.
  - Reset mid-computation aborts; ordy stays 0 until a new start.
- Start:
  - irdy is registered each clock; start = irdy & ~irdy_q, sampled only in IDLE or DONE.
  - A rising edge while BUSY is ignored. irdy held high for several cycles produces one start.
- On start, in the same edge:
  - latch in_a..in_d into working regs a,b,c,d and into saved regs;
  - latch data into X[0..15];
  - clear ordy; step=0; FSM=BUSY.
- BUSY, one step per clock, step n = 0..47:
  - t = a + f(b,c,d) + X[k(n)] + K(n) (mod 2^32); a' = rotl(t, s(n)); then (a,b,c,d) <= (d, a', b, c).
  - Round 1 (n 0..15): f = (b&c)|(~b&d); K = 0; k = n; s cycles 3,7,11,19.
  - Round 2 (n 16..31): f = (b&c)|(b&d)|(c&d); K = 0x5A827999; k order 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; s cycles 3,5,9,13.
  - Round 3 (n 32..47): f = b^c^d; K = 0x6ED9EBA1; k order 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; s cycles 3,9,11,15.
  - All additions wrap modulo 2^32.
- After step 47:
  - one FINAL cycle computes out_x = saved_x + working_x (mod 2^32);
  - ordy=1, FSM=DONE.
- Latency: ordy rises exactly 50 clock edges after the start edge (1 load + 48 steps + 1 final).
- DONE holds out_* and ordy until the next start edge; ordy then drops at that edge.
- Changes on in_* or data after the start edge do not affect the result.
- ordy is never high while BUSY. Outputs are stable whenever ordy=1.

Test Plan:
- Empty message: X[0]=0x00000080, other words 0, in = 67452301/EFCDAB89/98BADCFE/10325476, pulse irdy 2 cycles -> after 50 cycles ordy=1; out = E0CFD631, 31E96AD1, D7593CB7, C089C0E0 (digest 31d6cfe0d16ae931b73c59d7e0c089c0).
- "abc": X[0]=0x80636261, X[14]=0x18, others 0, standard IV -> out = 7A0148A4, 52D821AF, E80AC15F, 9D72A67A.
- Latency/hold: count edges from start to ordy (=50). irdy high 10 cycles yields one run. Outputs stable for 20 idle cycles.
- Busy retrigger: second irdy edge at step 20 with different data is ignored; result equals first run. A new edge after DONE drops ordy next edge and recomputes.
- Reset mid-run: assert rst_n low at step 30 -> ordy=0, outputs 0 immediately. After release, a new run gives the correct result.
- Input isolation: change data and in_* every cycle after the start -> result unchanged from the latched values.
